// File: rtl/spell_exec_engine_if.sv
// Request/acknowledge memory port between the spell execute engine and the code/data memories.
interface spell_exec_engine_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_type;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (output mem_req, mem_we, mem_type, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_type, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/spell_exec_engine.sv
// Spell CPU execute engine: owns the data stack and retires one opcode per start/done transaction.
// Optional SPELL_EXEC_MUL_EN adds a shift-add "*" opcode; otherwise "*" pushes 8'h2A like any literal.
module spell_exec_engine #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 32,
    parameter int unsigned DELAY_SCALE = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    opcode,
    input  logic [DATA_WIDTH-1:0]         pc,
    input  logic                          out_of_order_exec,
    output logic                          done,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         next_pc,
    output logic                          sleep,
    output logic                          err_underflow,
    output logic                          err_overflow,
    spell_exec_engine_if.master           mem,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic [DATA_WIDTH-1:0]         stack_top
);
    localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W   = IDX_W + 1;
    localparam int unsigned CNT_W  = DATA_WIDTH + $clog2(DELAY_SCALE + 1);
`ifdef SPELL_EXEC_MUL_EN
    localparam int unsigned MCNT_W = $clog2(DATA_WIDTH + 1);
`endif

    typedef enum logic [2:0] {
        IDLE, EXEC, MEM, DELAY, DONE
`ifdef SPELL_EXEC_MUL_EN
        , MUL
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic [DATA_WIDTH-1:0] top_q, top_d, pc_q, pc_d, next_pc_q, next_pc_d;
    logic [7:0]            op_q, op_d;
    logic                  ooo_q, ooo_d, done_q, done_d, busy_q, busy_d;
    logic                  sleep_q, sleep_d, err_uf_q, err_uf_d, err_of_q, err_of_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [1:0]            mem_type_q, mem_type_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef SPELL_EXEC_MUL_EN
    logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d, mul_sum;
    logic [MCNT_W-1:0]     mul_cnt_q, mul_cnt_d;
`endif

    logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                  wr0_en, wr1_en;
    logic [IDX_W-1:0]      wr0_idx, wr1_idx;
    logic [DATA_WIDTH-1:0] wr0_data, wr1_data;

    logic [IDX_W-1:0]      idx_t, idx_b, idx_c, idx_n;
    logic [DATA_WIDTH-1:0] stk_b, top_pop1, top_pop2, alu;
    logic [SP_W-1:0]       need;
    logic                  push_op;

    assign idx_t    = IDX_W'(sp_q - SP_W'(1));
    assign idx_b    = IDX_W'(sp_q - SP_W'(2));
    assign idx_c    = IDX_W'(sp_q - SP_W'(3));
    assign idx_n    = IDX_W'(sp_q);
    assign stk_b    = stack_q[idx_b];
    assign top_pop1 = (sp_q >= SP_W'(2)) ? stk_b : '0;
    assign top_pop2 = (sp_q >= SP_W'(3)) ? stack_q[idx_c] : '0;
`ifdef SPELL_EXEC_MUL_EN
    assign mul_sum  = mul_b_q[0] ? mul_acc_q + mul_a_q : mul_acc_q;
`endif

    // Opcode decode: required stack depth, whether the op grows the stack, and the binary ALU result.
    always_comb begin
        need    = '0;
        push_op = 1'b0;
        case (op_q)
            "+", "-", "&", "^", "|", "@", "!", "w", "x": need = SP_W'(2);
            ">", "<", "=", ",", "?", "r":                need = SP_W'(1);
            "2": begin
                need    = SP_W'(1);
                push_op = 1'b1;
            end
            "z", 8'hff: ;
`ifdef SPELL_EXEC_MUL_EN
            "*": need = SP_W'(2);
`endif
            default: push_op = 1'b1;
        endcase
        case (op_q)
            "+":     alu = stk_b + top_q;
            "-":     alu = stk_b - top_q;
            "&":     alu = stk_b & top_q;
            "^":     alu = stk_b ^ top_q;
            default: alu = stk_b | top_q;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        top_d       = top_q;
        op_d        = op_q;
        pc_d        = pc_q;
        ooo_d       = ooo_q;
        next_pc_d   = next_pc_q;
        sleep_d     = sleep_q;
        err_uf_d    = err_uf_q;
        err_of_d    = err_of_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_type_d  = mem_type_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        wr0_en      = 1'b0;
        wr0_idx     = '0;
        wr0_data    = '0;
        wr1_en      = 1'b0;
        wr1_idx     = '0;
        wr1_data    = '0;
`ifdef SPELL_EXEC_MUL_EN
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_acc_d   = mul_acc_q;
        mul_cnt_d   = mul_cnt_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                op_d     = opcode;
                pc_d     = pc;
                ooo_d    = out_of_order_exec;
                sleep_d  = 1'b0;
                err_uf_d = 1'b0;
                err_of_d = 1'b0;
                state_d  = EXEC;
            end
            EXEC: begin
                state_d   = DONE;
                next_pc_d = ooo_q ? pc_q : pc_q + DATA_WIDTH'(1);
                if (sp_q < need) begin
                    err_uf_d = 1'b1;
                end else if (push_op && sp_q == SP_W'(STACK_DEPTH)) begin
                    err_of_d = 1'b1;
                end else begin
                    case (op_q)
                        "+", "-", "&", "^", "|": begin
                            wr0_en = 1'b1; wr0_idx = idx_b; wr0_data = alu;
                            sp_d   = sp_q - SP_W'(1);
                            top_d  = alu;
                        end
                        ">", "<": begin
                            wr0_en   = 1'b1; wr0_idx = idx_t;
                            wr0_data = (op_q == ">") ? top_q >> 1 : top_q << 1;
                            top_d    = wr0_data;
                        end
                        "=": begin
                            next_pc_d = top_q;
                            sp_d      = sp_q - SP_W'(1);
                            top_d     = top_pop1;
                        end
                        "@": if (stk_b != '0) begin
                            next_pc_d = top_q;
                            wr0_en = 1'b1; wr0_idx = idx_b; wr0_data = stk_b - DATA_WIDTH'(1);
                            sp_d   = sp_q - SP_W'(1);
                            top_d  = wr0_data;
                        end else begin
                            sp_d  = sp_q - SP_W'(2);
                            top_d = top_pop2;
                        end
                        ",": begin
                            sp_d  = sp_q - SP_W'(1);
                            top_d = top_pop1;
                            if (top_q != '0) begin
                                cnt_d   = CNT_W'(top_q) * CNT_W'(DELAY_SCALE) - CNT_W'(1);
                                state_d = DELAY;
                            end
                        end
                        "2": begin
                            wr0_en = 1'b1; wr0_idx = idx_n; wr0_data = top_q;
                            sp_d   = sp_q + SP_W'(1);
                        end
                        "x": begin
                            wr0_en = 1'b1; wr0_idx = idx_t; wr0_data = stk_b;
                            wr1_en = 1'b1; wr1_idx = idx_b; wr1_data = top_q;
                            top_d  = stk_b;
                        end
                        "?", "r": begin
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_type_d = (op_q == "?") ? 2'd2 : 2'd1;
                            mem_addr_d = top_q;
                            state_d    = MEM;
                        end
                        "!", "w": begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_type_d  = (op_q == "!") ? 2'd2 : 2'd1;
                            mem_addr_d  = top_q;
                            mem_wdata_d = stk_b;
                            sp_d        = sp_q - SP_W'(2);
                            top_d       = top_pop2;
                            state_d     = MEM;
                        end
                        "z", 8'hff: sleep_d = 1'b1;
`ifdef SPELL_EXEC_MUL_EN
                        "*": begin
                            mul_a_d   = top_q;
                            mul_b_d   = stk_b;
                            mul_acc_d = '0;
                            mul_cnt_d = MCNT_W'(DATA_WIDTH - 1);
                            state_d   = MUL;
                        end
`endif
                        default: begin
                            wr0_en = 1'b1; wr0_idx = idx_n; wr0_data = DATA_WIDTH'(op_q);
                            sp_d   = sp_q + SP_W'(1);
                            top_d  = wr0_data;
                        end
                    endcase
                end
            end
            MEM: if (mem.mem_ack) begin
                mem_req_d  = 1'b0;
                mem_type_d = 2'd0;
                state_d    = DONE;
                if (!mem_we_q) begin
                    wr0_en = 1'b1; wr0_idx = idx_t; wr0_data = mem.mem_rdata;
                    top_d  = mem.mem_rdata;
                end
            end
            DELAY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = DONE;
            end
`ifdef SPELL_EXEC_MUL_EN
            // One multiplier bit per cycle; the last step retires the product in place of B.
            MUL: begin
                mul_acc_d = mul_sum;
                mul_a_d   = mul_a_q << 1;
                mul_b_d   = mul_b_q >> 1;
                mul_cnt_d = mul_cnt_q - MCNT_W'(1);
                if (mul_cnt_q == '0) begin
                    wr0_en  = 1'b1; wr0_idx = idx_b; wr0_data = mul_sum;
                    sp_d    = sp_q - SP_W'(1);
                    top_d   = mul_sum;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            top_q       <= '0;
            op_q        <= '0;
            pc_q        <= '0;
            ooo_q       <= 1'b0;
            next_pc_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            sleep_q     <= 1'b0;
            err_uf_q    <= 1'b0;
            err_of_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_type_q  <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
`ifdef SPELL_EXEC_MUL_EN
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_acc_q   <= '0;
            mul_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            top_q       <= top_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            ooo_q       <= ooo_d;
            next_pc_q   <= next_pc_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            sleep_q     <= sleep_d;
            err_uf_q    <= err_uf_d;
            err_of_q    <= err_of_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_type_q  <= mem_type_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
`ifdef SPELL_EXEC_MUL_EN
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_acc_q   <= mul_acc_d;
            mul_cnt_q   <= mul_cnt_d;
`endif
        end
    end

    // Stack storage carries no reset; entries above sp are never observed.
    always_ff @(posedge clock) begin
        if (wr0_en) stack_q[wr0_idx] <= wr0_data;
        if (wr1_en) stack_q[wr1_idx] <= wr1_data;
    end

    assign done          = done_q;
    assign busy          = busy_q;
    assign next_pc       = next_pc_q;
    assign sleep         = sleep_q;
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;
    assign sp            = sp_q;
    assign stack_top     = top_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_type  = mem_type_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: doc/spell_exec_engine.md
Name: spell_exec_engine

Overview:
- Multi-cycle, parametrised execute engine for the spell CPU. Owns the data stack internally rather than taking top/below-top from outside.
- Executes one opcode per start/done transaction and drives a request/acknowledge memory port.
- Counts out the "," delay itself and flags stack over/underflow instead of wrapping.
- Sits between fetch/decode and the code/data memories; the top-level sequencer supplies opcode and pc.

Parameters:
- DATA_WIDTH, 8, width of stack entries, pc, memory address and memory data.
- STACK_DEPTH, 32, number of stack entries (power of two, ≥2).
- DELAY_SCALE, 1, clock cycles per unit of "," delay (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin executing opcode; sampled only in IDLE
- opcode  in  8  ASCII opcode
- pc  in  DATA_WIDTH  address of current opcode
- out_of_order_exec  in  1  when 1, next_pc = pc (no increment)
- done  out  1  one-cycle pulse: opcode retired
- busy  out  1  high from start acceptance until done
- next_pc  out  DATA_WIDTH  valid while done=1
- sleep  out  1  set by "z"/8'hff; cleared by reset or next accepted start
- err_underflow  out  1  valid with done; held until next start
- err_overflow  out  1  valid with done; held until next start
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_type  out  2  0 = none, 1 = data, 2 = code
- mem_addr  out  DATA_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_ack  in  1  completes request
- sp  out  $clog2(STACK_DEPTH)+1  current entry count (0 = empty)
- stack_top  out  DATA_WIDTH  top entry; 0 when empty

Behaviour:
- Reset: state IDLE; sp=0; all outputs 0; stack contents don't-care. Reset in any state aborts the op, drops mem_req at once, and emits no done.
- States:
  - IDLE: start → EXEC.
  - EXEC: one cycle; decode and check stack.
  - MEM: mem_req held until mem_ack.
  - DELAY: counter.
  - DONE: one-cycle done; → IDLE.
- start while busy: ignored.
- Latency: ALU, stack and jump ops take 2 cycles from start to done. Memory ops take 2 cycles plus ack wait plus 1. Delay ops take 2 cycles plus n·DELAY_SCALE.
- next_pc defaults to pc+1 (mod 2^DATA_WIDTH), or pc when out_of_order_exec=1.
- Notation: T = top, B = below-top. All arithmetic is mod 2^DATA_WIDTH.
- Opcodes:
  - "+ - & ^ |": B op T; pop 2, push 1.
  - "> <": logical shift T by 1.
  - "=": next_pc = T; pop 1.
  - "@": if B≠0, next_pc = T, pop 1, new top = B−1. Otherwise pop 2.
  - ",": n = T; pop 1; wait n·DELAY_SCALE cycles. n=0 → no wait.
  - "2": duplicate T.
  - "x": swap T and B.
  - "?": read, type code, addr T. "r": same with type data. Both replace T with mem_rdata.
  - "!": write, type code, addr T, data B; pop 2. "w": same with type data.
  - "z", 8'hff: sleep=1; stack untouched.
  - Any other byte: push opcode zero-extended to DATA_WIDTH.
- Required depth before op:
  - 2: binary ops, "@", "!", "w", "x".
  - 1: shifts, "=", ",", "2", "?", "r".
- Errors:
  - Underflow: sp below required depth → err_underflow=1.
  - Overflow: a push with sp=STACK_DEPTH → err_overflow=1.
  - On either error: no stack change, no memory request, no delay; straight to DONE with next_pc per default rule.
- Memory: mem_addr, mem_type, mem_we and mem_wdata stable while mem_req=1. mem_ack in the same cycle mem_req first rises is legal. mem_ack outside MEM is ignored.
- mem_type=0 whenever mem_req=0.

Optional Feature:
- SPELL_EXEC_MUL_EN defined: opcode "*" computes B·T (low DATA_WIDTH bits), pops 2, pushes 1, needs depth 2. Implemented as a shift-add unit taking DATA_WIDTH cycles in a MUL state before DONE.
- Undefined: "*" is a literal push of 8'h2A, and the MUL state and its logic are absent.

Test Plan:
- Reset, push "A" (0x41), push 0x05, op "+" → done 2 cycles after each start; stack_top=0x46, sp=1, next_pc=pc+1.
- Stack 0x03, 0x10, op "@" at pc=0x20 → next_pc=0x10, stack_top=0x02, sp=1. Repeat with B=0 → sp drops by 2, next_pc=0x21.
- Stack 0x07, 0x30, op "w", mem_ack 3 cycles late → mem_req/we/type=1/1/1, addr 0x30, wdata 0x07 held; done 1 cycle after ack; sp=0.
- DELAY_SCALE=2, stack_top=4, op "," → done exactly 10 cycles after start. With stack_top=0 → done at 2 cycles.
- Empty stack, op "+" → err_underflow=1 with done, sp=0. 32 pushes then 1 more → err_overflow=1, sp=32, stack_top unchanged.
- Reset asserted during MEM wait → mem_req low next cycle, no done, sp=0. With SPELL_EXEC_MUL_EN: 0x0C "*" 0x0B → 0x84 after 8 MUL cycles.
